// File: rtl/video_axis_timing_gen.sv
// Parametrised video timing generator with test-pattern source and an AXI4-Stream
// video master fed through a small FIFO; overflow drops the rest of the frame.
module video_axis_timing_gen #(
    parameter int unsigned H_VISIBLE        = 640,
    parameter int unsigned H_FP             = 16,
    parameter int unsigned H_SYNC           = 96,
    parameter int unsigned H_BP             = 48,
    parameter int unsigned V_VISIBLE        = 480,
    parameter int unsigned V_FP             = 10,
    parameter int unsigned V_SYNC           = 2,
    parameter int unsigned V_BP             = 33,
    parameter bit          SYNC_ACTIVE_HIGH = 1'b1,
    parameter int unsigned DATA_W           = 24,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned CW               = 12
) (
    input  logic                          pixel_clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [1:0]                    pattern_sel,
    input  logic [DATA_W-1:0]             solid_rgb,
    input  logic                          clear_flags,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          video_on,
    output logic [CW-1:0]                 pixel_x,
    output logic [CW-1:0]                 pixel_y,
    output logic                          frame_start,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow_sticky
);

    localparam int unsigned H_MAX    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_MAX    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = H_VISIBLE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = V_VISIBLE + V_FP + V_SYNC - 1;
    localparam int unsigned C        = DATA_W / 3;
    localparam int unsigned BAR_W    = H_VISIBLE / 8;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned FW       = DATA_W + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDrop} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   y_q, y_d;
    logic            hsync_q, vsync_q, video_on_q, frame_start_q;
    logic            running_d, hs_win_d, vs_win_d, video_on_d, frame_start_d;
    logic            line_end, frame_end;
    logic [1:0]      pat_q;
    logic            sticky_q;

    logic [FW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            full, empty, push_req, push, pop, overflow;
    logic [FW-1:0]   push_word, head;

    logic [2:0]        bar_idx;
    logic [2:0]        bar_rgb;
    logic [C-1:0]      grad;
    logic [DATA_W-1:0] pixel;

    // ---------------------------------------------------------------- counters / FSM
    assign line_end  = (x_q == CW'(H_MAX - 1));
    assign frame_end = line_end && (y_q == CW'(V_MAX - 1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            StIdle: begin
                x_d = '0;
                y_d = '0;
                if (enable) state_d = StRun;
            end
            StRun, StDrop: begin
                if (line_end) begin
                    x_d = '0;
                    y_d = frame_end ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
                // A dropped frame always resynchronises at the wrap.
                if (frame_end)     state_d = enable ? StRun : StIdle;
                else if (overflow) state_d = StDrop;
            end
            default: state_d = StIdle;
        endcase
    end

    // Timing outputs are computed from next-state coordinates so they line up
    // with the registered pixel_x/pixel_y.
    always_comb begin
        running_d     = (state_d != StIdle);
        hs_win_d      = running_d && (x_d >= CW'(HS_START)) && (x_d <= CW'(HS_END));
        vs_win_d      = running_d && (y_d >= CW'(VS_START)) && (y_d <= CW'(VS_END));
        video_on_d    = running_d && (x_d < CW'(H_VISIBLE)) && (y_d < CW'(V_VISIBLE));
        frame_start_d = running_d && (x_d == '0) && (y_d == '0);
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= !SYNC_ACTIVE_HIGH;
            vsync_q       <= !SYNC_ACTIVE_HIGH;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            pat_q         <= 2'd0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= SYNC_ACTIVE_HIGH ? hs_win_d : !hs_win_d;
            vsync_q       <= SYNC_ACTIVE_HIGH ? vs_win_d : !vs_win_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            if (frame_start_d) pat_q <= pattern_sel;
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

    // ---------------------------------------------------------------- pattern source
    // Bar index is the count of bar boundaries already passed; the last bar
    // naturally absorbs any remainder of H_VISIBLE/8.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_q >= CW'(k * BAR_W)) bar_idx = 3'(k);
        end
    end

    always_comb begin
        bar_rgb = 3'b000;
        unique case (bar_idx)
            3'd0: bar_rgb = 3'b111;
            3'd1: bar_rgb = 3'b110;
            3'd2: bar_rgb = 3'b011;
            3'd3: bar_rgb = 3'b010;
            3'd4: bar_rgb = 3'b101;
            3'd5: bar_rgb = 3'b100;
            3'd6: bar_rgb = 3'b001;
            3'd7: bar_rgb = 3'b000;
            default: bar_rgb = 3'b000;
        endcase
    end

    assign grad = C'(x_q);

    always_comb begin
        pixel = '0;
        unique case (pat_q)
            2'd0: pixel = solid_rgb;
            2'd1: pixel = {{C{bar_rgb[2]}}, {C{bar_rgb[1]}}, {C{bar_rgb[0]}}};
            2'd2: pixel = (x_q[5] ^ y_q[5]) ? '0 : '1;
            2'd3: pixel = {grad, grad, grad};
            default: pixel = '0;
        endcase
    end

    // ---------------------------------------------------------------- output FIFO
    assign full      = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign pop       = !empty && m_axis_tready;
    assign push_req  = (state_q == StRun) && video_on_q;
    assign push      = push_req && (!full || pop);
    assign overflow  = push_req && full && !pop;
    assign push_word = {pixel, (x_q == '0) && (y_q == '0), (x_q == CW'(H_VISIBLE - 1))};

    always_ff @(posedge pixel_clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? '0 : head[FW-1:2];
    assign m_axis_tuser  = !empty && head[1];
    assign m_axis_tlast  = !empty && head[0];
    assign fifo_level    = count_q;

    // ---------------------------------------------------------------- flags
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n)         sticky_q <= 1'b0;
        else if (overflow)    sticky_q <= 1'b1;
        else if (clear_flags) sticky_q <= 1'b0;
    end

    assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_video_axis_timing_gen.sv
// Scoreboard bench for video_axis_timing_gen on a tiny 8x4 raster (16x8 total),
// FIFO depth 4: timing, patterns, backpressure, overflow/drop, enable and reset.
module tb_video_axis_timing_gen;

    logic        pixel_clk_tb = 1'b0;
    logic        reset_n      = 1'b0;
    logic        enable       = 1'b0;
    logic [1:0]  pattern_sel  = 2'd0;
    logic [23:0] solid_rgb    = 24'h123456;
    logic        clear_flags  = 1'b0;
    logic        m_axis_tready = 1'b1;
    logic        hsync, vsync, video_on, frame_start;
    logic [11:0] pixel_x, pixel_y;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic [2:0]  fifo_level;
    logic        overflow_sticky;

    int checks = 0;
    int errors = 0;
    int user_cnt = 0;
    int last_cnt = 0;
    int test_id = 0;
    logic [25:0] exp_q[$];
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 pixel_clk_tb = ~pixel_clk_tb;

    video_axis_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE_HIGH(1'b1), .DATA_W(24), .FIFO_DEPTH(4), .CW(12)
    ) dut (
        .pixel_clk(pixel_clk_tb),
        .reset_n(reset_n),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb),
        .clear_flags(clear_flags),
        .hsync(hsync),
        .vsync(vsync),
        .video_on(video_on),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .frame_start(frame_start),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .fifo_level(fifo_level),
        .overflow_sticky(overflow_sticky)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] pix(input int pat, input int x, input int y);
        case (pat)
            0:       return solid_rgb;
            1:       return bars[x];
            2:       return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
            default: return {3{8'(x)}};
        endcase
    endfunction

    task automatic push_beats(input int pat, input int lines, input int width);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < width; x++) begin
                exp_q.push_back({pix(pat, x, y), 1'(x == 0 && y == 0), 1'(x == 7)});
            end
        end
    endtask

    // Pops one expected beat per handshake; also checks hold-stability under stall.
    task automatic monitor();
        logic stall;
        logic [25:0] held, beat, e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge pixel_clk_tb);
            beat = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
            if (!reset_n) begin
                stall = 1'b0;
            end else begin
                if (stall) check("stall_hold", {m_axis_tvalid, beat}, {1'b1, held});
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got 0x%0h, required no beat (t=%0t)",
                                 beat, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", beat, e);
                    end
                    user_cnt += int'(m_axis_tuser);
                    last_cnt += int'(m_axis_tlast);
                end
                stall = m_axis_tvalid && !m_axis_tready;
                held  = beat;
            end
        end
    endtask

    task automatic start_run(input int pat);
        @(posedge pixel_clk_tb);
        #1;
        enable      = 1'b1;
        pattern_sel = 2'(pat);
    endtask

    // Cycle c = c-th cycle in RUN; checks at posedge+1, drives right after.
    task automatic run_loop(input int frames);
        int ex, ey;
        logic hs, vs, von, fs;
        for (int c = 0; c < frames * 128; c++) begin
            @(posedge pixel_clk_tb);
            #1;
            ex  = c % 16;
            ey  = (c / 16) % 8;
            hs  = (ex >= 10 && ex <= 12);
            vs  = (ey >= 5 && ey <= 6);
            von = (ex < 8 && ey < 4);
            fs  = (ex == 0 && ey == 0);
            check("timing", {pixel_x, pixel_y, hsync, vsync, video_on, frame_start},
                  {12'(ex), 12'(ey), hs, vs, von, fs});
            if (c == (frames - 1) * 128 + 1) enable = 1'b0;
            case (test_id)
                2: if (c == 5) pattern_sel = 2'd2;
                3: m_axis_tready = (fifo_level >= 3'd3) ? 1'b1 : 1'($urandom_range(0, 1));
                4: begin
                    if (c == 4) begin
                        check("ovf_full_level", fifo_level, 3'd4);
                        check("ovf_not_yet", overflow_sticky, 1'b0);
                        clear_flags = 1'b1;
                    end
                    if (c == 5) begin
                        check("ovf_set_wins", overflow_sticky, 1'b1);
                        check("ovf_level_hold", fifo_level, 3'd4);
                        clear_flags = 1'b0;
                    end
                    if (c == 10) clear_flags = 1'b1;
                    if (c == 11) begin
                        check("ovf_cleared", overflow_sticky, 1'b0);
                        clear_flags = 1'b0;
                    end
                    if (c == 20) begin
                        check("drop_level", fifo_level, 3'd4);
                        m_axis_tready = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(posedge pixel_clk_tb);
            #1;
            if (exp_q.size() == 0 && !m_axis_tvalid) break;
        end
        check("drain", {32'(exp_q.size()), m_axis_tvalid}, 33'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_xy"}, {pixel_x, pixel_y}, 24'd0);
        check({tag, "_sync"}, {hsync, vsync}, 2'b00);
        check({tag, "_von_fs"}, {video_on, frame_start}, 2'b00);
        check({tag, "_axis_ctl"}, {m_axis_tvalid, m_axis_tuser, m_axis_tlast}, 3'b000);
        check({tag, "_tdata"}, m_axis_tdata, 24'd0);
        check({tag, "_level"}, fifo_level, 3'd0);
        check({tag, "_sticky"}, overflow_sticky, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge pixel_clk_tb);
        #1;
        check_reset_outputs("reset");
        @(posedge pixel_clk_tb);
        #1;
        reset_n = 1'b1;

        // A: colour bars, 2 frames, full timing check, then idle
        test_id = 1;
        push_beats(1, 4, 8);
        push_beats(1, 4, 8);
        start_run(1);
        run_loop(2);
        for (int i = 0; i < 20; i++) begin
            @(posedge pixel_clk_tb);
            #1;
            check("idle", {pixel_x, pixel_y, hsync, vsync, video_on, frame_start}, 28'd0);
        end
        wait_drain();

        // B: solid frame; pattern change mid-frame only lands on the next frame
        test_id = 2;
        push_beats(0, 4, 8);
        push_beats(2, 4, 8);
        start_run(0);
        run_loop(2);
        wait_drain();

        // C: gradient under random backpressure (bench never lets the FIFO fill)
        test_id = 3;
        user_cnt = 0;
        last_cnt = 0;
        push_beats(3, 4, 8);
        push_beats(3, 4, 8);
        push_beats(3, 4, 8);
        start_run(3);
        run_loop(3);
        m_axis_tready = 1'b1;
        wait_drain();
        check("tuser_count", 32'(user_cnt), 32'd3);
        check("tlast_count", 32'(last_cnt), 32'd12);
        check("no_overflow", overflow_sticky, 1'b0);

        // D: overflow with tready=0 from frame start, drop, resync next frame
        test_id = 4;
        @(posedge pixel_clk_tb);
        #1;
        m_axis_tready = 1'b0;
        push_beats(1, 1, 4);
        push_beats(1, 4, 8);
        start_run(1);
        run_loop(2);
        wait_drain();

        // E: async reset mid-line with 3 queued entries, then restart
        test_id = 0;
        @(posedge pixel_clk_tb);
        #1;
        m_axis_tready = 1'b0;
        start_run(3);
        repeat (4) @(posedge pixel_clk_tb);
        #1;
        check("pre_reset_level", fifo_level, 3'd3);
        check("pre_reset_x", pixel_x, 12'd3);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge pixel_clk_tb);
        #1;
        reset_n = 1'b1;
        m_axis_tready = 1'b1;
        push_beats(3, 4, 8);
        run_loop(1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_axis_timing_gen.md
Name: video_axis_timing_gen

Overview:
Parametrised successor to the fixed 640x480 timing/stream path in top. It generates sync timing and pixel coordinates for any resolution, and renders a selectable test pattern. Visible pixels are pushed through an internal FIFO onto an AXI4-Stream video master with tuser (SOF) and tlast (EOL). Unlike the current path it tolerates tready backpressure: overflow is detected and flagged, and the stream is resynchronised at the next frame.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_VISIBLE, 480, active lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
SYNC_ACTIVE_HIGH, 1, 1 = sync asserted high inside the sync window, 0 = asserted low
DATA_W, 24, tdata width; three equal channels R,G,B (MSB..LSB), DATA_W divisible by 3
FIFO_DEPTH, 16, output FIFO entries, power of two, >= 2
CW, 12, coordinate counter width; must hold H_MAX-1 and V_MAX-1

Ports:
pixel_clk  in  1  pixel clock; all logic on its rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  run request, sampled at frame boundaries only
pattern_sel  in  2  0 solid, 1 colour bars, 2 checker, 3 gradient; sampled at frame start
solid_rgb  in  DATA_W  colour used for pattern 0
clear_flags  in  1  single-cycle clear of overflow_sticky
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
video_on  out  1  high when (pixel_x, pixel_y) is in the visible area
pixel_x  out  CW  current column
pixel_y  out  CW  current row
frame_start  out  1  one-cycle pulse when pixel_x=0 and pixel_y=0 while running
m_axis_tdata  out  DATA_W  pixel data
m_axis_tvalid  out  1  FIFO non-empty
m_axis_tuser  out  1  start of frame; set only on pixel (0,0)
m_axis_tlast  out  1  end of line; set only on pixel x=H_VISIBLE-1
m_axis_tready  in  1  downstream ready
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow_sticky  out  1  latched overflow indication

Behaviour:
- Derived values: H_MAX = H_VISIBLE+H_FP+H_SYNC+H_BP; V_MAX likewise from the vertical parameters.
- Reset (async, while reset_n=0):
  - pixel_x = pixel_y = 0; video_on = 0; frame_start = 0.
  - hsync and vsync at their inactive level (= !SYNC_ACTIVE_HIGH).
  - FIFO empty: tvalid, tuser, tlast = 0; tdata = 0; fifo_level = 0.
  - overflow_sticky = 0; FSM = IDLE.
  - Reset mid-frame discards all FIFO contents.
- FSM states: IDLE, RUN, DROP.
  - IDLE->RUN on the first cycle enable=1; counters start at (0,0) that cycle.
  - RUN/DROP at frame wrap (x=H_MAX-1, y=V_MAX-1): go to IDLE if enable=0, else RUN. DROP always exits at frame wrap.
  - RUN->DROP on overflow.
- IDLE: counters held at 0, syncs inactive, video_on=0, no pushes. The FIFO keeps draining.
- Counters (RUN/DROP): x increments every cycle and wraps H_MAX-1 -> 0. y increments when x wraps, and wraps V_MAX-1 -> 0.
- Sync timing:
  - hsync is active when H_VISIBLE+H_FP <= x <= H_VISIBLE+H_FP+H_SYNC-1.
  - vsync is active when V_VISIBLE+V_FP <= y <= V_VISIBLE+V_FP+V_SYNC-1.
  - video_on = (x<H_VISIBLE && y<V_VISIBLE).
  - hsync, vsync, video_on and frame_start are all registered and aligned to the same cycle as pixel_x/pixel_y.
- pattern_sel is latched when a frame starts at (0,0). Changing it mid-frame has no effect until the next frame.
- Patterns, with C = DATA_W/3 bits per channel:
  - 0: solid_rgb.
  - 1: eight vertical bars, each H_VISIBLE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black. The last bar absorbs any remainder.
  - 2: 32x32 checker, white where x[5]^y[5] = 0, else black.
  - 3: all three channels = x[C-1:0].
- Push: each cycle with video_on=1 in RUN, push {tdata, tuser = (x==0 && y==0), tlast = (x==H_VISIBLE-1)}.
- Latency: a pixel is pushed in the cycle its coordinates are presented. It is visible on m_axis_* at the earliest on the next cycle.
- AXI handshake:
  - Transfer occurs when tvalid && tready.
  - tdata/tuser/tlast are stable while tvalid=1 and tready=0.
  - Push and pop in the same cycle leave fifo_level unchanged, and this holds when the FIFO is full.
- Overflow: a push while full with no simultaneous pop does the following:
  - the pixel is dropped;
  - overflow_sticky is set;
  - the FSM enters DROP.
- DROP behaviour:
  - no pushes occur; counters and syncs keep running normally;
  - entries already queued still drain;
  - the stream therefore restarts cleanly with a tuser pixel.
- Flags: clear_flags clears overflow_sticky. If a set and a clear occur in the same cycle, set wins.

Test Plan:
- H_VISIBLE=8, H_FP=2, H_SYNC=3, H_BP=3, V_VISIBLE=4, V_FP=1, V_SYNC=2, V_BP=1, tready=1, enable=1 -> hsync high for x=10..12 and vsync high for y=5..6 every frame; x wraps at 15 and y at 7; 32 beats per frame; tuser only on beat 0; tlast on every 8th beat.
- Same params, pattern 1, tready=1 -> beats 0..7 of each line = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Same params, tready=0 from reset, FIFO_DEPTH=4 -> fifo_level reaches 4, then overflow_sticky=1 on the 5th visible pixel and FSM=DROP. With tready=1 afterwards, 4 beats drain, then the next beat has tuser=1 with data of (0,0).
- Random tready (50%), pattern 3, 3 frames -> no overflow; received beats equal x[7:0] per channel; tdata stable during stalls; tuser/tlast counts 3 and 12.
- Drop enable mid-frame -> frame completes and the FSM enters IDLE at wrap; x=y=0, syncs inactive, no further beats. Re-enable -> frame_start pulse and tuser beat.
- Assert reset_n=0 mid-line with the FIFO at 3 -> outputs immediately return to reset values and fifo_level=0. After release with enable=1 -> the first beat is (0,0) with tuser=1.
